// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
// Parametrised SPI master. Moves one DATA_WIDTH word per transfer and supports
// all four CPOL/CPHA modes, MSB- or LSB-first order, a programmable SCLK
// half-period (CLK_DIV clk cycles) and NUM_SLAVES active-low chip selects.
// Transfer sequence: IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE.
//
// Ports:
//   clk                 system clock, all logic on posedge
//   reset               synchronous active-high reset
//   start               transfer request, sampled only in IDLE
//   slaveSelect         target slave 1..NUM_SLAVES (0 or larger is rejected)
//   cpol / cpha         SPI mode; lsb_first selects bit order
//   masterDataToSend    TX word, captured when start is accepted
//   masterDataReceived  last completed RX word (registered)
//   busy / done         transfer in progress / one-cycle end-of-transfer pulse
//   sel_err             one-cycle pulse when start is rejected
//   CS                  active-low chip selects, CS[k-1] selects slave k
//   SCLK / MOSI / MISO  serial interface
// -----------------------------------------------------------------------------
module spi_master_param #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 3,
    parameter int CLK_DIV    = 2,
    parameter int SEL_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SEL_W-1:0]      slaveSelect,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [DATA_WIDTH-1:0] masterDataToSend,
    output logic [DATA_WIDTH-1:0] masterDataReceived,
    output logic                  busy,
    output logic                  done,
    output logic                  sel_err,
    output logic [NUM_SLAVES-1:0] CS,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        TRANSFER = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t                  state_r,   state_s;
    logic [DIV_W-1:0]        div_r,     div_s;
    logic [EDGE_W-1:0]       edge_r,    edge_s;
    logic [DATA_WIDTH-1:0]   tx_r,      tx_s;
    logic [DATA_WIDTH-1:0]   rx_r,      rx_s;
    logic                    cpha_r,    cpha_s;
    logic                    lsb_r,     lsb_s;
    logic                    sclk_r,    sclk_s;
    logic                    mosi_r,    mosi_s;
    logic [NUM_SLAVES-1:0]   cs_r,      cs_s;
    logic                    busy_r,    busy_s;
    logic                    done_r,    done_s;
    logic                    sel_err_r, sel_err_s;
    logic [DATA_WIDTH-1:0]   rx_data_r, rx_data_s;
    logic                    sel_valid_s;
    logic [NUM_SLAVES-1:0]   cs_sel_s;
    logic                    half_end_s;

    // Bit that goes on the wire next, given the shift order.
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        if (lsb) begin
            return w[0];
        end else begin
            return w[DATA_WIDTH-1];
        end
    endfunction

    // Drop the bit just sent so the next one moves into the output position.
    function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        if (lsb) begin
            return {1'b0, w[DATA_WIDTH-1:1]};
        end else begin
            return {w[DATA_WIDTH-2:0], 1'b0};
        end
    endfunction

    // Insert a received bit; after DATA_WIDTH shifts the first bit sits at the MSB
    // (MSB-first) or the LSB (LSB-first).
    function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] w,
                                                       input logic lsb, input logic b);
        if (lsb) begin
            return {b, w[DATA_WIDTH-1:1]};
        end else begin
            return {w[DATA_WIDTH-2:0], b};
        end
    endfunction

    // Decode slaveSelect into a validity flag and the active-low CS pattern.
    always_comb begin
        sel_valid_s = (slaveSelect != {SEL_W{1'b0}}) && (slaveSelect <= SEL_W'(NUM_SLAVES));
        for (int k = 0; k < NUM_SLAVES; k++) begin
            cs_sel_s[k] = (slaveSelect == SEL_W'(k + 1)) ? 1'b0 : 1'b1;
        end
    end

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_s    = state_r;
        div_s      = div_r;
        edge_s     = edge_r;
        tx_s       = tx_r;
        rx_s       = rx_r;
        cpha_s     = cpha_r;
        lsb_s      = lsb_r;
        sclk_s     = sclk_r;
        mosi_s     = mosi_r;
        cs_s       = cs_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        sel_err_s  = 1'b0;
        rx_data_s  = rx_data_r;
        half_end_s = (div_r == DIV_LAST);

        case (state_r)
            IDLE: begin
                sclk_s = cpol;
                mosi_s = 1'b0;
                cs_s   = {NUM_SLAVES{1'b1}};
                busy_s = 1'b0;
                div_s  = {DIV_W{1'b0}};
                if (start && sel_valid_s) begin
                    state_s = SETUP;
                    busy_s  = 1'b1;
                    cs_s    = cs_sel_s;
                    tx_s    = masterDataToSend;
                    rx_s    = {DATA_WIDTH{1'b0}};
                    cpha_s  = cpha;
                    lsb_s   = lsb_first;
                    edge_s  = {EDGE_W{1'b0}};
                    // cpha=0 presents the first bit before the first edge.
                    mosi_s  = cpha ? 1'b0 : first_bit(masterDataToSend, lsb_first);
                end else if (start) begin
                    sel_err_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end

            SETUP: begin
                if (half_end_s) begin
                    state_s = TRANSFER;
                    div_s   = {DIV_W{1'b0}};
                    edge_s  = {EDGE_W{1'b0}};
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end

            TRANSFER: begin
                if (half_end_s) begin
                    div_s  = {DIV_W{1'b0}};
                    sclk_s = ~sclk_r;
                    edge_s = edge_r + EDGE_W'(1);
                    // Even edge index = leading edge, odd = trailing edge.
                    if (!edge_r[0]) begin
                        if (cpha_r) begin
                            mosi_s = first_bit(tx_r, lsb_r);
                            tx_s   = shift_tx(tx_r, lsb_r);
                        end else begin
                            rx_s = shift_rx(rx_r, lsb_r, MISO);
                        end
                    end else begin
                        if (cpha_r) begin
                            rx_s = shift_rx(rx_r, lsb_r, MISO);
                        end else if (edge_r != EDGE_LAST) begin
                            tx_s   = shift_tx(tx_r, lsb_r);
                            mosi_s = first_bit(shift_tx(tx_r, lsb_r), lsb_r);
                        end else begin
                            mosi_s = mosi_r;
                        end
                    end
                    if (edge_r == EDGE_LAST) begin
                        state_s = HOLD;
                    end else begin
                        state_s = TRANSFER;
                    end
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end

            HOLD: begin
                if (half_end_s) begin
                    state_s   = IDLE;
                    div_s     = {DIV_W{1'b0}};
                    cs_s      = {NUM_SLAVES{1'b1}};
                    mosi_s    = 1'b0;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                    rx_data_s = rx_r;
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            div_r     <= {DIV_W{1'b0}};
            edge_r    <= {EDGE_W{1'b0}};
            tx_r      <= {DATA_WIDTH{1'b0}};
            rx_r      <= {DATA_WIDTH{1'b0}};
            cpha_r    <= 1'b0;
            lsb_r     <= 1'b0;
            sclk_r    <= 1'b0;
            mosi_r    <= 1'b0;
            cs_r      <= {NUM_SLAVES{1'b1}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sel_err_r <= 1'b0;
            rx_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r   <= state_s;
            div_r     <= div_s;
            edge_r    <= edge_s;
            tx_r      <= tx_s;
            rx_r      <= rx_s;
            cpha_r    <= cpha_s;
            lsb_r     <= lsb_s;
            sclk_r    <= sclk_s;
            mosi_r    <= mosi_s;
            cs_r      <= cs_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            sel_err_r <= sel_err_s;
            rx_data_r <= rx_data_s;
        end
    end

    assign masterDataReceived = rx_data_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign sel_err            = sel_err_r;
    assign CS                 = cs_r;
    assign SCLK               = sclk_r;
    assign MOSI               = mosi_r;

endmodule

// File: tb/tb_spi_master_param.sv
// -----------------------------------------------------------------------------
// tb_spi_master_param
// Directed-vector bench for spi_master_param. One instance uses the default
// parameters (8-bit, CLK_DIV=2); a second uses DATA_WIDTH=16, CLK_DIV=1 for
// the back-to-back transfer case. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_spi_master_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  slaveSelect;
    logic        cpol, cpha, lsb_first;
    logic [7:0]  masterDataToSend;
    logic [7:0]  masterDataReceived;
    logic        busy, done, sel_err;
    logic [2:0]  CS;
    logic        SCLK, MOSI, MISO;
    logic        loop_en, slave_bit;

    logic        start16;
    logic [15:0] tx16, rx16;
    logic        busy16, done16, selerr16, sclk16, mosi16;
    logic [2:0]  cs16;

    int n_vec  = 0;
    int n_miss = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    assign MISO = loop_en ? MOSI : slave_bit;

    spi_master_param u_dut (
        .clk(clk), .reset(reset), .start(start), .slaveSelect(slaveSelect),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .masterDataToSend(masterDataToSend), .masterDataReceived(masterDataReceived),
        .busy(busy), .done(done), .sel_err(sel_err), .CS(CS),
        .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
    );

    spi_master_param #(.DATA_WIDTH(16), .NUM_SLAVES(3), .CLK_DIV(1), .SEL_W(4)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .slaveSelect(4'd2),
        .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0),
        .masterDataToSend(tx16), .masterDataReceived(rx16),
        .busy(busy16), .done(done16), .sel_err(selerr16), .CS(cs16),
        .SCLK(sclk16), .MOSI(mosi16), .MISO(mosi16)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full 8-bit transfer with protocol monitoring. MOSI is captured just
    // after each leading edge; with loop=0 the slave drives slave_word MSB-first
    // on leading edges (valid for cpha=1 only).
    task automatic do_xfer(input string tag, input logic [7:0] tx, input logic [3:0] sel,
                           input logic pol, input logic pha, input logic lsb,
                           input logic loop, input logic [7:0] slave_word,
                           input logic [7:0] exp_rx);
        logic [7:0] tx_seen;
        logic [2:0] cs_exp;
        logic       sclk_prev, mosi_prev, lead, got_done, first_mosi;
        int         n, edges, ebit, cs_bad, mosi_bad, err_seen;
        tx_seen = 8'h00; cs_exp = 3'b111; cs_exp[int'(sel) - 1] = 1'b0;
        n = 0; edges = 0; ebit = 0; cs_bad = 0; mosi_bad = 0; err_seen = 0;
        got_done = 1'b0; first_mosi = 1'b0;
        loop_en = loop; slave_bit = 1'b0;
        @(negedge clk);
        masterDataToSend = tx; slaveSelect = sel; cpol = pol; cpha = pha; lsb_first = lsb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Changes after the accepting edge must be ignored.
        masterDataToSend = ~tx; cpha = ~pha; lsb_first = ~lsb;
        check_val({tag, "_busy_start"}, busy, 1'b1);
        check_val({tag, "_cs_start"}, CS, cs_exp);
        sclk_prev = SCLK; mosi_prev = MOSI;
        while (!got_done && n < 200) begin
            @(posedge clk); #1;
            n++;
            start = (n == 10) ? 1'b1 : 1'b0;
            if (sel_err) err_seen++;
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (CS !== cs_exp) cs_bad++;
                lead = (SCLK != sclk_prev) && (SCLK != pol);
                if (SCLK != sclk_prev) begin
                    edges++;
                    if (lead && ebit < 8) begin
                        if (ebit == 0) first_mosi = MOSI;
                        if (lsb) tx_seen[ebit] = MOSI; else tx_seen[7 - ebit] = MOSI;
                        if (!loop) slave_bit = slave_word[7 - ebit];
                        ebit++;
                    end
                end
                if (MOSI != mosi_prev && !((SCLK != sclk_prev) && (lead == pha))) mosi_bad++;
            end
            sclk_prev = SCLK; mosi_prev = MOSI;
        end
        // done first visible after edge T+36, i.e. during cycle T+37.
        check_val({tag, "_done_latency"}, n + 1, 37);
        check_val({tag, "_sclk_edges"}, edges, 16);
        check_val({tag, "_mosi_word"}, tx_seen, tx);
        check_val({tag, "_first_mosi"}, first_mosi, lsb ? tx[0] : tx[7]);
        check_val({tag, "_rx"}, masterDataReceived, exp_rx);
        check_val({tag, "_cs_during"}, cs_bad, 0);
        check_val({tag, "_mosi_timing"}, mosi_bad, 0);
        check_val({tag, "_no_err_busy"}, err_seen, 0);
        check_val({tag, "_cs_end"}, CS, 3'b111);
        check_val({tag, "_busy_end"}, busy, 1'b0);
        check_val({tag, "_mosi_end"}, MOSI, 1'b0);
        check_val({tag, "_sclk_idle"}, SCLK, pol);
        @(posedge clk); #1;
        check_val({tag, "_done_pulse"}, done, 1'b0);
        check_val({tag, "_rx_hold"}, masterDataReceived, exp_rx);
    endtask

    task automatic sel_reject(input string tag, input logic [3:0] sel);
        @(negedge clk);
        slaveSelect = sel; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val({tag, "_sel_err"}, sel_err, 1'b1);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_cs"}, CS, 3'b111);
        @(posedge clk); #1;
        check_val({tag, "_sel_err_once"}, sel_err, 1'b0);
        check_val({tag, "_busy2"}, busy, 1'b0);
        check_val({tag, "_cs2"}, CS, 3'b111);
    endtask

    // Abort a mode-1 transfer at its 4th SCLK edge, then run a clean one.
    task automatic reset_mid_xfer();
        int edges, n, dones;
        logic sclk_prev;
        edges = 0; n = 0; dones = 0;
        loop_en = 1'b1;
        @(negedge clk);
        masterDataToSend = 8'hC3; slaveSelect = 4'd1; cpol = 1'b0; cpha = 1'b1;
        lsb_first = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sclk_prev = SCLK;
        while (edges < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (SCLK != sclk_prev) edges++;
            sclk_prev = SCLK;
        end
        check_val("rst_reach_edge4", edges, 4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("rst_cs", CS, 3'b111);
        check_val("rst_sclk", SCLK, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_rx", masterDataReceived, 8'h00);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check_val("rst_no_done", dones, 0);
        do_xfer("after_rst", 8'h5A, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h5A);
    endtask

    // Back-to-back 16-bit transfers with start held across done.
    task automatic b2b_16();
        int d1, d2, cs_high;
        d1 = 0; d2 = 0; cs_high = 0;
        @(negedge clk);
        tx16 = 16'hBEEF; start16 = 1'b1;
        @(posedge clk); #1;
        tx16 = 16'h1234;
        check_val("b2b_busy", busy16, 1'b1);
        for (int n = 1; n <= 100 && d2 == 0; n++) begin
            @(posedge clk); #1;
            if (done16) begin
                if (d1 == 0) begin
                    d1 = n;
                    check_val("b2b_rx1", rx16, 16'hBEEF);
                end else begin
                    d2 = n;
                end
            end
            if (n == 36) start16 = 1'b0;
            if (d2 == 0 && cs16 == 3'b111) cs_high++;
        end
        check_val("b2b_latency1", d1 + 1, 35);
        check_val("b2b_latency2", d2 - d1, 35);
        check_val("b2b_cs_gap", cs_high, 1);
        check_val("b2b_rx2", rx16, 16'h1234);
        check_val("b2b_cs_end", cs16, 3'b111);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; slaveSelect = 4'd0; cpol = 1'b0; cpha = 1'b0;
        lsb_first = 1'b0; masterDataToSend = 8'h00; loop_en = 1'b1; slave_bit = 1'b0;
        start16 = 1'b0; tx16 = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_cs", CS, 3'b111);
        check_val("reset_sclk", SCLK, 1'b0);
        check_val("reset_mosi", MOSI, 1'b0);
        check_val("reset_rx", masterDataReceived, 8'h00);
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_done", done, 1'b0);
        check_val("reset_sel_err", sel_err, 1'b0);
        check_val("reset_cs16", cs16, 3'b111);
        reset = 1'b0;
        @(posedge clk); #1;

        do_xfer("mode0", 8'hA5, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hA5);
        do_xfer("mode3", 8'h96, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C);
        do_xfer("lsb",   8'h01, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01);
        sel_reject("sel0", 4'd0);
        sel_reject("sel5", 4'd5);
        reset_mid_xfer();
        b2b_16();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
